pc_ctrl: RTL and testbench

Fetch sequencer that drives the program counter's `en`/`next_pc` pair. It boots the PC to a reset vector and advances it sequentially as instruction memory delivers instructions. It holds the PC on stalls and memory wait states, buffers branch redirects that arrive while fetch is blocked, and redirects to a trap vector with a saved return address. It sits between the pc register, instruction memory and the decode/execute stage.

---
 rtl/pc_ctrl_pkg.sv | 21 ++
 rtl/pc_redirect_buf.sv | 40 ++++
 rtl/pc_ctrl.sv | 120 ++++++++++++
 tb/tb_pc_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// instruction length and the default boot/trap vectors.
package pc_ctrl_pkg;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   localparam int unsigned ILEN = 4;

   localparam logic [31:0] DefResetVector = 32'h0000_0000;
   localparam logic [31:0] DefTrapVector  = 32'h0000_0100;

   // True when an address is not on an instruction boundary.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr & 32'(ILEN - 1)) != 32'd0;
   endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one branch redirect that arrived while fetch was blocked; a newer
// set overwrites the held target.
module pc_redirect_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        pend_set,
   input  logic        pend_clr,
   input  logic [31:0] target,
   output logic        pend_valid,
   output logic [31:0] pend_target
);

   logic        valid_q, valid_d;
   logic [31:0] target_q, target_d;

   always_comb begin
      valid_d  = valid_q;
      target_d = target_q;
      if (pend_set) begin
         valid_d  = 1'b1;
         target_d = target;
      end else if (pend_clr) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         target_q <= 32'd0;
      end else begin
         valid_q  <= valid_d;
         target_q <= target_d;
      end
   end

   assign pend_valid  = valid_q;
   assign pend_target = target_q;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch sequencer: boots the PC, advances it on accepted fetches, holds it on
// wait states/stalls, and redirects on branches, traps and trap returns.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DefResetVector,
   parameter logic [31:0] TRAP_VECTOR  = DefTrapVector
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        pc_en,
   output logic [31:0] pc_next,
   output logic        imem_req,
   input  logic        imem_ready,
   output logic        instr_valid,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        trap_req,
   input  logic        trap_ret,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] epc,
   output logic        misaligned
);

   state_e      state_q, state_d;
   logic [31:0] epc_q, epc_d;
   logic        misaligned_q, misaligned_d;
   logic        go;
   logic        br_misaligned;
   logic        pend_set, pend_clr, pend_valid;
   logic [31:0] pend_target;

   assign go            = imem_ready & ~stall;
   assign br_misaligned = branch_taken & is_misaligned(branch_target);

   pc_redirect_buf u_redirect_buf (
      .clk         (clk),
      .rst         (rst),
      .pend_set    (pend_set),
      .pend_clr    (pend_clr),
      .target      (branch_target),
      .pend_valid  (pend_valid),
      .pend_target (pend_target)
   );

   always_comb begin
      state_d      = state_q;
      epc_d        = epc_q;
      misaligned_d = 1'b0;
      pend_set     = 1'b0;
      pend_clr     = 1'b0;
      pc_en        = 1'b1;
      pc_next      = pc_in;
      imem_req     = 1'b0;
      instr_valid  = 1'b0;
      unique case (state_q)
         StBoot: begin
            pc_next = RESET_VECTOR;
            state_d = StRun;
         end
         StRun: begin
            imem_req    = 1'b1;
            instr_valid = go & ~trap_req & ~trap_ret;
            if (trap_req) begin
               pc_next  = TRAP_VECTOR;
               epc_d    = pc_in;
               pend_clr = 1'b1;
            end else if (trap_ret) begin
               pc_next  = epc_q;
               pend_clr = 1'b1;
            end else if (br_misaligned) begin
               pc_next      = TRAP_VECTOR;
               epc_d        = pc_in;
               misaligned_d = 1'b1;
            end else if (go) begin
               if (branch_taken) begin
                  pc_next  = branch_target;
                  pend_clr = 1'b1;
               end else if (pend_valid) begin
                  pc_next  = pend_target;
                  pend_clr = 1'b1;
               end else begin
                  pc_en = 1'b0;
               end
            end else if (branch_taken) begin
               // Blocked: keep the PC (pc_en must stay 1) and remember the redirect.
               pend_set = 1'b1;
            end
            if (halt_req && go && !trap_req && !trap_ret) begin
               state_d = StHalt;
            end
         end
         StHalt: begin
            if (resume) begin
               state_d = StRun;
            end
         end
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StBoot;
         epc_q        <= 32'd0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         epc_q        <= epc_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign epc        = epc_q;
   assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table followed by random
// stimulus compared against a behavioural model of the fetch sequencer.
module tb_pc_ctrl;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst, imem_ready, stall, branch_taken, trap_req, trap_ret, halt_req, resume;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic        pc_en, imem_req, instr_valid, misaligned;
   logic [31:0] pc_next, epc;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Behavioural model state: mode 0=boot, 1=run, 2=halt.
   int          m_mode;
   bit          m_pv, m_mis;
   logic [31:0] m_pt, m_epc, m_pc;

   typedef struct {
      logic        rst, rdy, stl, br;
      logic [31:0] tgt;
      logic        trp, trt, hlt, res;
      logic [31:0] pc;
      logic        en;
      logic [31:0] nxt;
      logic        req, vld;
      logic [31:0] epc;
      logic        mis;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   // The program counter register the controller steers.
   always_ff @(posedge clk) pc <= pc_en ? pc_next : pc + 32'd4;

   pc_ctrl #(
      .RESET_VECTOR (RV),
      .TRAP_VECTOR  (TV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_in         (pc),
      .pc_en         (pc_en),
      .pc_next       (pc_next),
      .imem_req      (imem_req),
      .imem_ready    (imem_ready),
      .instr_valid   (instr_valid),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .trap_req      (trap_req),
      .trap_ret      (trap_ret),
      .halt_req      (halt_req),
      .resume        (resume),
      .epc           (epc),
      .misaligned    (misaligned)
   );

   function automatic vec_t v(input logic r, rdy, stl, br, input logic [31:0] tgt,
                              input logic trp, trt, hlt, res, input logic [31:0] p,
                              input logic en, input logic [31:0] nxt, input logic req, vld,
                              input logic [31:0] e, input logic mis);
      vec_t x;
      x.rst = r; x.rdy = rdy; x.stl = stl; x.br = br; x.tgt = tgt;
      x.trp = trp; x.trt = trt; x.hlt = hlt; x.res = res;
      x.pc = p; x.en = en; x.nxt = nxt; x.req = req; x.vld = vld; x.epc = e; x.mis = mis;
      return x;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endfunction

   // One clock: drive inputs, check outputs (against the table row or the
   // model), then advance the model across the edge.
   task automatic step(input vec_t s, input bit use_tbl);
      bit          go, e_en, e_req, e_vld;
      logic [31:0] e_nxt;
      int          n_mode;
      bit          n_pv, n_mis;
      logic [31:0] n_pt, n_epc, n_pc;
      @(negedge clk);
      rst = s.rst; imem_ready = s.rdy; stall = s.stl; branch_taken = s.br;
      branch_target = s.tgt; trap_req = s.trp; trap_ret = s.trt;
      halt_req = s.hlt; resume = s.res;
      #2;
      go = s.rdy && !s.stl;
      n_mode = m_mode; n_pv = m_pv; n_pt = m_pt; n_epc = m_epc; n_mis = 0;
      e_en = 1; e_nxt = m_pc; e_req = 0; e_vld = 0;
      if (m_mode == 0) begin
         e_nxt = RV;
         n_mode = 1;
      end else if (m_mode == 1) begin
         e_req = 1;
         e_vld = go && !s.trp && !s.trt;
         if (s.trp) begin
            e_nxt = TV; n_epc = m_pc; n_pv = 0;
         end else if (s.trt) begin
            e_nxt = m_epc; n_pv = 0;
         end else if (s.br && (s.tgt % 4) != 0) begin
            e_nxt = TV; n_epc = m_pc; n_mis = 1;
         end else if (go && s.br) begin
            e_nxt = s.tgt; n_pv = 0;
         end else if (go && m_pv) begin
            e_nxt = m_pt; n_pv = 0;
         end else if (go) begin
            e_en = 0;
         end else if (s.br) begin
            n_pv = 1; n_pt = s.tgt;
         end
         if (s.hlt && go && !s.trp && !s.trt) n_mode = 2;
      end else if (s.res) begin
         n_mode = 1;
      end
      n_pc = e_en ? e_nxt : m_pc + 32'd4;
      if (s.rst) begin
         n_mode = 0; n_pv = 0; n_pt = 0; n_epc = 0; n_mis = 0;
      end
      if (use_tbl) begin
         chk("pc", pc, s.pc);
         chk("pc_en", 32'(pc_en), 32'(s.en));
         if (s.en) chk("pc_next", pc_next, s.nxt);
         chk("imem_req", 32'(imem_req), 32'(s.req));
         chk("instr_valid", 32'(instr_valid), 32'(s.vld));
         chk("epc", epc, s.epc);
         chk("misaligned", 32'(misaligned), 32'(s.mis));
      end else begin
         chk("rnd_pc", pc, m_pc);
         chk("rnd_pc_en", 32'(pc_en), 32'(e_en));
         if (e_en) chk("rnd_pc_next", pc_next, e_nxt);
         chk("rnd_imem_req", 32'(imem_req), 32'(e_req));
         chk("rnd_instr_valid", 32'(instr_valid), 32'(e_vld));
         chk("rnd_epc", epc, m_epc);
         chk("rnd_misaligned", 32'(misaligned), 32'(m_mis));
      end
      @(posedge clk);
      cyc++;
      m_mode = n_mode; m_pv = n_pv; m_pt = n_pt; m_epc = n_epc; m_mis = n_mis; m_pc = n_pc;
   endtask

   initial begin
      vec_t r;
      // rst rdy stl br tgt trp trt hlt res | pc en nxt req vld epc mis
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h000,1,32'h000,0,0,32'h00,0)); // boot
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h000,0,32'h000,1,1,32'h00,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h004,0,32'h000,1,1,32'h00,0));
      tbl.push_back(v(0,0,0,0,32'h00,0,0,0,0, 32'h008,1,32'h008,1,0,32'h00,0)); // wait
      tbl.push_back(v(0,0,0,0,32'h00,0,0,0,0, 32'h008,1,32'h008,1,0,32'h00,0));
      tbl.push_back(v(0,0,0,0,32'h00,0,0,0,0, 32'h008,1,32'h008,1,0,32'h00,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h008,0,32'h000,1,1,32'h00,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h00C,0,32'h000,1,1,32'h00,0));
      tbl.push_back(v(0,1,1,1,32'h40,0,0,0,0, 32'h010,1,32'h010,1,0,32'h00,0)); // br stall
      tbl.push_back(v(0,1,1,0,32'h00,0,0,0,0, 32'h010,1,32'h010,1,0,32'h00,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h010,1,32'h040,1,1,32'h00,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h040,0,32'h000,1,1,32'h00,0));
      tbl.push_back(v(0,1,0,1,32'h20,0,0,0,0, 32'h044,1,32'h020,1,1,32'h00,0));
      tbl.push_back(v(0,1,0,1,32'h80,1,0,0,0, 32'h020,1,32'h100,1,0,32'h00,0)); // trap+br
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h100,0,32'h000,1,1,32'h20,0));
      tbl.push_back(v(0,1,1,0,32'h00,0,0,0,0, 32'h104,1,32'h104,1,0,32'h20,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h104,0,32'h000,1,1,32'h20,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,1,0,0, 32'h108,1,32'h020,1,0,32'h20,0)); // ret
      tbl.push_back(v(0,1,0,1,32'h30,0,0,0,0, 32'h020,1,32'h030,1,1,32'h20,0));
      tbl.push_back(v(0,1,0,1,32'h42,0,0,0,0, 32'h030,1,32'h100,1,1,32'h20,0)); // misal
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h100,0,32'h000,1,1,32'h30,1));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h104,0,32'h000,1,1,32'h30,0));
      tbl.push_back(v(0,1,0,1,32'h08,0,0,0,0, 32'h108,1,32'h008,1,1,32'h30,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,1,0, 32'h008,0,32'h000,1,1,32'h30,0)); // halt
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h00C,1,32'h00C,0,0,32'h30,0));
      tbl.push_back(v(0,1,0,0,32'h00,1,0,0,0, 32'h00C,1,32'h00C,0,0,32'h30,0));
      tbl.push_back(v(0,1,1,1,32'h80,0,0,0,0, 32'h00C,1,32'h00C,0,0,32'h30,0));
      tbl.push_back(v(0,0,0,0,32'h00,0,0,0,0, 32'h00C,1,32'h00C,0,0,32'h30,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,1, 32'h00C,1,32'h00C,0,0,32'h30,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h00C,0,32'h000,1,1,32'h30,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,1,0, 32'h010,0,32'h000,1,1,32'h30,0));
      tbl.push_back(v(1,1,0,0,32'h00,0,0,0,0, 32'h014,1,32'h014,0,0,32'h30,0)); // rst
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h014,1,32'h000,0,0,32'h00,0));
      tbl.push_back(v(0,1,0,0,32'h00,0,0,0,0, 32'h000,0,32'h000,1,1,32'h00,0));

      // Two reset cycles; afterwards the pc register holds the boot vector.
      rst = 1; imem_ready = 1; stall = 0; branch_taken = 0; branch_target = 0;
      trap_req = 0; trap_ret = 0; halt_req = 0; resume = 0;
      repeat (2) @(posedge clk);
      m_mode = 0; m_pv = 0; m_pt = 0; m_epc = 0; m_mis = 0; m_pc = RV;

      foreach (tbl[i]) step(tbl[i], 1'b1);

      for (int i = 0; i < 3000; i++) begin
         r.rst = ($urandom_range(0, 127) == 0);
         r.rdy = ($urandom_range(0, 3) != 0);
         r.stl = ($urandom_range(0, 3) == 0);
         r.br  = ($urandom_range(0, 3) == 0);
         r.tgt = {22'd0, 8'($urandom_range(0, 255)), 2'd0};
         if ($urandom_range(0, 7) == 0) r.tgt[1:0] = 2'($urandom_range(1, 3));
         r.trp = ($urandom_range(0, 15) == 0);
         r.trt = ($urandom_range(0, 15) == 0);
         r.hlt = ($urandom_range(0, 15) == 0);
         r.res = ($urandom_range(0, 3) == 0);
         r.pc = 0; r.en = 0; r.nxt = 0; r.req = 0; r.vld = 0; r.epc = 0; r.mis = 0;
         step(r, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
